// File: rtl/dsp48a1_slice.sv
// rtl/dsp48a1_slice.sv - pipelined pre-add / multiply / post-add DSP slice
module dsp48a1_slice #(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic        i_clk,
    input  logic        i_rsta,
    input  logic        i_rstb,
    input  logic        i_rstc,
    input  logic        i_rstd,
    input  logic        i_rstm,
    input  logic        i_rstp,
    input  logic        i_rstcarryin,
    input  logic        i_rstopmode,
    input  logic [17:0] i_a,
    input  logic [17:0] i_b,
    input  logic [17:0] i_d,
    input  logic [17:0] i_bcin,
    input  logic [47:0] i_c,
    input  logic [47:0] i_pcin,
    input  logic        i_carryin,
    input  logic [7:0]  i_opmode,
    input  logic        i_cea,
    input  logic        i_ceb,
    input  logic        i_cec,
    input  logic        i_ced,
    input  logic        i_cem,
    input  logic        i_cep,
    input  logic        i_cecarryin,
    input  logic        i_ceopmode,
    output logic [17:0] o_bcout,
    output logic [35:0] o_m,
    output logic [47:0] o_p,
    output logic [47:0] o_pcout,
    output logic        o_carryout,
    output logic        o_carryoutf
);

    localparam bit L_B_DIRECT  = (B_INPUT == "DIRECT");
    localparam bit L_B_CASCADE = (B_INPUT == "CASCADE");
    localparam bit L_CIN_OPM   = (CARRYINSEL == "OPMODE5");
    localparam bit L_CIN_PORT  = (CARRYINSEL == "CARRYIN");

    logic [17:0] r_a0, r_a1, r_b0, r_b1, r_d;
    logic [47:0] r_c;
    logic [35:0] r_m;
    logic [7:0]  r_opmode;
    logic        r_cin, r_carryout;

    logic [17:0] w_a0, w_a1, w_b_src, w_b0, w_b1, w_b1_in, w_d, w_pre;
    logic [47:0] w_c, w_x, w_z, w_p;
    logic [35:0] w_mult, w_m;
    logic [7:0]  w_opmode;
    logic        w_cin_src, w_cin, w_carryout;
    logic [48:0] w_x_cin, w_post;

    // A first stage
    always_ff @(posedge i_clk or posedge i_rsta)
        if (i_rsta) r_a0 <= '0;
        else if (i_cea) r_a0 <= i_a;
    assign w_a0 = (A0REG != 0) ? r_a0 : i_a;

    // A second stage, the multiplier's A operand
    always_ff @(posedge i_clk or posedge i_rsta)
        if (i_rsta) r_a1 <= '0;
        else if (i_cea) r_a1 <= w_a0;
    assign w_a1 = (A1REG != 0) ? r_a1 : w_a0;

    assign w_b_src = L_B_DIRECT ? i_b : (L_B_CASCADE ? i_bcin : 18'd0);

    // B first stage, feeds the pre-adder
    always_ff @(posedge i_clk or posedge i_rstb)
        if (i_rstb) r_b0 <= '0;
        else if (i_ceb) r_b0 <= w_b_src;
    assign w_b0 = (B0REG != 0) ? r_b0 : w_b_src;

    // D stage, the pre-adder's other operand
    always_ff @(posedge i_clk or posedge i_rstd)
        if (i_rstd) r_d <= '0;
        else if (i_ced) r_d <= i_d;
    assign w_d = (DREG != 0) ? r_d : i_d;

    // C stage, post-adder Z operand
    always_ff @(posedge i_clk or posedge i_rstc)
        if (i_rstc) r_c <= '0;
        else if (i_cec) r_c <= i_c;
    assign w_c = (CREG != 0) ? r_c : i_c;

    // OPMODE stage; every mode decision below uses this output
    always_ff @(posedge i_clk or posedge i_rstopmode)
        if (i_rstopmode) r_opmode <= '0;
        else if (i_ceopmode) r_opmode <= i_opmode;
    assign w_opmode = (OPMODEREG != 0) ? r_opmode : i_opmode;

    // Pre-adder wraps at 18 bits; OPMODE[4] chooses it or raw B0 for B1
    assign w_pre   = w_opmode[6] ? (w_d - w_b0) : (w_d + w_b0);
    assign w_b1_in = w_opmode[4] ? w_pre : w_b0;

    // B second stage, multiplier B operand and cascade out
    always_ff @(posedge i_clk or posedge i_rstb)
        if (i_rstb) r_b1 <= '0;
        else if (i_ceb) r_b1 <= w_b1_in;
    assign w_b1 = (B1REG != 0) ? r_b1 : w_b1_in;

    assign w_mult = {18'd0, w_a1} * {18'd0, w_b1};

    // Multiplier output stage
    always_ff @(posedge i_clk or posedge i_rstm)
        if (i_rstm) r_m <= '0;
        else if (i_cem) r_m <= w_mult;
    assign w_m = (MREG != 0) ? r_m : w_mult;

    assign w_cin_src = L_CIN_OPM ? w_opmode[5] : (L_CIN_PORT ? i_carryin : 1'b0);

    // Carry-in stage
    always_ff @(posedge i_clk or posedge i_rstcarryin)
        if (i_rstcarryin) r_cin <= 1'b0;
        else if (i_cecarryin) r_cin <= w_cin_src;
    assign w_cin = (CARRYINREG != 0) ? r_cin : w_cin_src;

    // X and Z operand selection
    always_comb begin
        w_x = 48'd0;
        w_z = 48'd0;
        case (w_opmode[1:0])
            2'd0: w_x = 48'd0;
            2'd1: w_x = {12'd0, w_m};
            2'd2: w_x = w_p;
            2'd3: w_x = {w_d[11:0], w_a1, w_b1};
        endcase
        case (w_opmode[3:2])
            2'd0: w_z = 48'd0;
            2'd1: w_z = i_pcin;
            2'd2: w_z = w_p;
            2'd3: w_z = w_c;
        endcase
    end

    // Subtract mode takes Z - (X + CIN); bit 48 is then the borrow
    assign w_x_cin = {1'b0, w_x} + {48'd0, w_cin};
    assign w_post  = w_opmode[7] ? ({1'b0, w_z} - w_x_cin) : ({1'b0, w_z} + w_x_cin);

    generate
        if (PREG != 0) begin : g_preg
            logic [47:0] r_p;
            // P stage, also the accumulator when fed back through X or Z
            always_ff @(posedge i_clk or posedge i_rstp)
                if (i_rstp) r_p <= '0;
                else if (i_cep) r_p <= w_post[47:0];
            assign w_p = r_p;
        end else begin : g_pcomb
            assign w_p = w_post[47:0];
        end
    endgenerate

    // Carry-out stage shares P's reset and enable
    always_ff @(posedge i_clk or posedge i_rstp)
        if (i_rstp) r_carryout <= 1'b0;
        else if (i_cep) r_carryout <= w_post[48];
    assign w_carryout = (CARRYOUTREG != 0) ? r_carryout : w_post[48];

    assign o_bcout     = w_b1;
    assign o_m         = w_m;
    assign o_p         = w_p;
    assign o_pcout     = w_p;
    assign o_carryout  = w_carryout;
    assign o_carryoutf = w_carryout;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// tb/tb_dsp48a1_slice.sv - self-checking bench for dsp48a1_slice
module tb_dsp48a1_slice;

    logic        clk = 1'b0;
    logic        rsta, rstb, rstc, rstd, rstm, rstp, rstcin, rstop;
    logic [17:0] a, b, d, bcin;
    logic [47:0] c, pcin;
    logic        carryin;
    logic [7:0]  opmode;
    logic        cea, ceb, cec, ced, cem, cep, cecin, ceop;

    logic [17:0] bcout1, bcout2;
    logic [35:0] m1, m2;
    logic [47:0] p1, p2, pcout1, pcout2;
    logic        co1, co2, cof1, cof2;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    dsp48a1_slice u_op5 (
        .i_clk(clk), .i_rsta(rsta), .i_rstb(rstb), .i_rstc(rstc), .i_rstd(rstd),
        .i_rstm(rstm), .i_rstp(rstp), .i_rstcarryin(rstcin), .i_rstopmode(rstop),
        .i_a(a), .i_b(b), .i_d(d), .i_bcin(bcin), .i_c(c), .i_pcin(pcin),
        .i_carryin(carryin), .i_opmode(opmode),
        .i_cea(cea), .i_ceb(ceb), .i_cec(cec), .i_ced(ced), .i_cem(cem), .i_cep(cep),
        .i_cecarryin(cecin), .i_ceopmode(ceop),
        .o_bcout(bcout1), .o_m(m1), .o_p(p1), .o_pcout(pcout1),
        .o_carryout(co1), .o_carryoutf(cof1)
    );

    dsp48a1_slice #(.CARRYINSEL("CARRYIN")) u_cin (
        .i_clk(clk), .i_rsta(rsta), .i_rstb(rstb), .i_rstc(rstc), .i_rstd(rstd),
        .i_rstm(rstm), .i_rstp(rstp), .i_rstcarryin(rstcin), .i_rstopmode(rstop),
        .i_a(a), .i_b(b), .i_d(d), .i_bcin(bcin), .i_c(c), .i_pcin(pcin),
        .i_carryin(carryin), .i_opmode(opmode),
        .i_cea(cea), .i_ceb(ceb), .i_cec(cec), .i_ced(ced), .i_cem(cem), .i_cep(cep),
        .i_cecarryin(cecin), .i_ceopmode(ceop),
        .o_bcout(bcout2), .o_m(m2), .o_p(p2), .o_pcout(pcout2),
        .o_carryout(co2), .o_carryoutf(cof2)
    );

    // Behavioural model: values held by each default-latency pipeline point
    logic [17:0] ma1 = '0, mb1 = '0, md = '0;
    logic [47:0] mc = '0, mp1 = '0, mp2 = '0;
    logic [35:0] mm = '0;
    logic [7:0]  mop = '0;
    logic        mcin1 = 1'b0, mcin2 = 1'b0, mco1 = 1'b0, mco2 = 1'b0;

    function automatic logic [47:0] x_of(input logic [7:0] op, input logic [47:0] p);
        case (op[1:0])
            2'd0: return 48'd0;
            2'd1: return {12'd0, mm};
            2'd2: return p;
            default: return {md[11:0], ma1, mb1};
        endcase
    endfunction

    function automatic logic [47:0] z_of(input logic [7:0] op, input logic [47:0] p);
        case (op[3:2])
            2'd0: return 48'd0;
            2'd1: return pcin;
            2'd2: return p;
            default: return mc;
        endcase
    endfunction

    // Plain integer arithmetic: sum beyond 2^48 is a carry, negative is a borrow
    task automatic post(input logic [47:0] z, input logic [47:0] x, input logic cin,
                        input logic sub, output logic [47:0] r, output logic cy);
        longint s;
        if (sub) s = longint'(z) - longint'(x) - longint'(cin);
        else     s = longint'(z) + longint'(x) + longint'(cin);
        r  = s[47:0];
        cy = sub ? (s < 0) : (s >= 64'h1_0000_0000_0000);
    endtask

    always @(posedge clk) begin
        int          t;
        logic [17:0] nb1;
        logic [47:0] np1, np2;
        logic        nco1, nco2;
        t   = mop[6] ? (int'(md) - int'(b)) : (int'(md) + int'(b));
        nb1 = mop[4] ? t[17:0] : b;
        post(z_of(mop, mp1), x_of(mop, mp1), mcin1, mop[7], np1, nco1);
        post(z_of(mop, mp2), x_of(mop, mp2), mcin2, mop[7], np2, nco2);
        if (rstm) mm = '0; else if (cem) mm = 36'(longint'(ma1) * longint'(mb1));
        if (rstp) begin mp1 = '0; mp2 = '0; mco1 = 0; mco2 = 0; end
        else if (cep) begin mp1 = np1; mp2 = np2; mco1 = nco1; mco2 = nco2; end
        if (rstcin) begin mcin1 = 0; mcin2 = 0; end
        else if (cecin) begin mcin1 = mop[5]; mcin2 = carryin; end
        if (rsta) ma1 = '0; else if (cea) ma1 = a;
        if (rstb) mb1 = '0; else if (ceb) mb1 = nb1;
        if (rstd) md = '0;  else if (ced) md = d;
        if (rstc) mc = '0;  else if (cec) mc = c;
        if (rstop) mop = '0; else if (ceop) mop = opmode;
    end

    always @(posedge rstp) begin
        mp1 = '0; mp2 = '0; mco1 = 1'b0; mco2 = 1'b0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("bcout",  64'(bcout1), 64'(mb1));
            check("m",      64'(m1),     64'(mm));
            check("p_op5",  64'(p1),     64'(mp1));
            check("pcout",  64'(pcout1), 64'(mp1));
            check("co_op5", 64'(co1),    64'(mco1));
            check("cof",    64'(cof1),   64'(mco1));
            check("p_cin",  64'(p2),     64'(mp2));
            check("co_cin", 64'(co2),    64'(mco2));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [47:0] p_a, p_b;
        {rsta, rstb, rstc, rstd, rstm, rstp, rstcin, rstop} = '1;
        {cea, ceb, cec, ced, cem, cep, cecin, ceop} = '1;
        a = 0; b = 0; d = 0; bcin = 0; c = 0; pcin = 0; carryin = 0; opmode = 0;
        cycles(2);
        @(negedge clk);
        check("rst_p",     64'(p1),     64'd0);
        check("rst_m",     64'(m1),     64'd0);
        check("rst_bcout", 64'(bcout1), 64'd0);
        check("rst_co",    64'(co1),    64'd0);
        cycles(1);
        {rsta, rstb, rstc, rstd, rstm, rstp, rstcin, rstop} = '0;
        cmp_en = 1'b1;

        a = 20; b = 10; d = 25; c = 350; opmode = 8'b00011101;
        cycles(4);
        @(negedge clk);
        check("add_bcout", 64'(bcout1), 64'd35);
        check("add_m",     64'(m1),     64'd700);
        check("add_p",     64'(p1),     64'd1050);
        check("add_co",    64'(co1),    64'd0);

        cycles(1);
        opmode = 8'b01011101;
        cycles(4);
        @(negedge clk);
        check("sub_bcout", 64'(bcout1), 64'd15);
        check("sub_m",     64'(m1),     64'd300);
        check("sub_p",     64'(p1),     64'd650);

        cycles(1);
        opmode = 8'b10011101;
        cycles(4);
        @(negedge clk);
        check("cm_p",  64'(p1),  64'hFFFF_FFFF_FEA2);
        check("cm_co", 64'(co1), 64'd1);

        cycles(1);
        a = 2; b = 3; opmode = 8'b00001001;
        cycles(5);
        @(negedge clk);
        check("acc_m", 64'(m1), 64'd6);
        p_a = p1;
        @(negedge clk);
        p_b = p1;
        check("acc_step", 64'(p_b - p_a), 64'd6);
        @(posedge clk); #1;
        cep = 1'b0;
        @(negedge clk);
        p_a = p1;
        cycles(3);
        @(negedge clk);
        check("cep_hold", 64'(p1), 64'(p_a));
        @(posedge clk); #1;
        cep = 1'b1;
        cycles(3);
        #2;
        rstp = 1'b1;
        #1;
        check("rstp_p",  64'(p1),  64'd0);
        check("rstp_co", 64'(co1), 64'd0);
        #1;
        rstp = 1'b0;

        cycles(1);
        a = 1; b = 2; d = 18'h3; opmode = 8'b00000011;
        cycles(5);
        @(negedge clk);
        check("concat_p", 64'(p1), 64'h0030_0004_0002);

        cycles(1);
        a = 0; c = 5; carryin = 1'b1; opmode = 8'b00001101;
        cycles(5);
        @(negedge clk);
        check("cinport_p", 64'(p2), 64'd6);
        check("cinop5_p",  64'(p1), 64'd5);

        cycles(2);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
